// File: rtl/alu_ctrl_decoder.sv
// alu_ctrl_decoder: RV32I ALU-control decoder behind a 2-entry FIFO (in: clk rst in_valid/in_ready inst flush; out: out_valid/out_ready alu_ctrl op1_sel op2_sel imm rd rs1 rs2 illegal)
module alu_ctrl_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_ctrl,
  output logic        op1_sel,
  output logic        op2_sel,
  output logic [31:0] imm,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        illegal
);
  localparam logic [3:0] SLL = 4'd0, SRL = 4'd1, SRA = 4'd2, ADD = 4'd3, SUB = 4'd4, XOR = 4'd5;
  localparam logic [3:0] OR = 4'd6, AND = 4'd7, SLT = 4'd8, SLTU = 4'd9, LUI = 4'd10;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [31:0] u_imm, i_imm, s_imm, sh_imm;
  logic alt, is_op, is_sh;
  logic [3:0] f3_alu, d_alu;
  logic d_op1, d_op2, d_ill;
  logic [31:0] d_imm;
  logic [1:0][53:0] mem;
  logic [1:0] count;
  logic rp, wp, acc, em;
  assign f3 = inst[14:12];
  assign f7 = inst[31:25];
  assign u_imm = {inst[31:12], 12'h0};
  assign i_imm = {{20{inst[31]}}, inst[31:20]};
  assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign sh_imm = {27'h0, inst[24:20]};
  assign is_op = inst[6:0] == 7'b0110011;
  assign is_sh = f3 == 3'b001 || f3 == 3'b101;
  assign alt = inst[30] & (is_op | f3 == 3'b101);
  always_comb begin
    case (f3)
      3'b000:  f3_alu = alt ? SUB : ADD;
      3'b001:  f3_alu = SLL;
      3'b010:  f3_alu = SLT;
      3'b011:  f3_alu = SLTU;
      3'b100:  f3_alu = XOR;
      3'b101:  f3_alu = alt ? SRA : SRL;
      3'b110:  f3_alu = OR;
      default: f3_alu = AND;
    endcase
  end
  always_comb begin
    d_alu = ADD;
    d_op1 = 1'b0;
    d_op2 = 1'b0;
    d_imm = '0;
    d_ill = 1'b0;
    case (inst[6:0])
      7'b0110011: begin
        d_alu = f3_alu;
        d_ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      7'b0010011: begin
        d_alu = f3_alu;
        d_op2 = 1'b1;
        d_imm = is_sh ? sh_imm : i_imm;
        d_ill = is_sh && f7 != 7'h00 && !(f7 == 7'h20 && f3 == 3'b101);
      end
      7'b0110111: begin
        d_alu = LUI;
        d_op2 = 1'b1;
        d_imm = u_imm;
      end
      7'b0010111: begin
        d_op1 = 1'b1;
        d_op2 = 1'b1;
        d_imm = u_imm;
      end
      7'b0000011: begin
        d_op2 = 1'b1;
        d_imm = i_imm;
      end
      7'b0100011: begin
        d_op2 = 1'b1;
        d_imm = s_imm;
      end
      default: d_ill = 1'b1;
    endcase
    // Illegal words of any opcode collapse to the neutral ADD/rs1/rs2/zero-imm shape
    if (d_ill) begin
      d_alu = ADD;
      d_op1 = 1'b0;
      d_op2 = 1'b0;
      d_imm = '0;
    end
  end
  assign in_ready = ~count[1] & ~rst;
  assign out_valid = count != 2'd0;
  assign acc = in_valid & in_ready;
  assign em = out_valid & out_ready;
  assign {alu_ctrl, op1_sel, op2_sel, imm, rd, rs1, rs2, illegal} = mem[rp];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
      count <= 2'd0;
      rp <= 1'b0;
      wp <= 1'b0;
    end else if (flush) begin
      count <= 2'd0;
      rp <= 1'b0;
      wp <= 1'b0;
    end else begin
      if (acc) mem[wp] <= {d_alu, d_op1, d_op2, d_imm, inst[11:7], inst[19:15], inst[24:20], d_ill};
      wp <= wp ^ acc;
      rp <= rp ^ em;
      count <= count + {1'b0, acc} - {1'b0, em};
    end
  end
endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// tb_alu_ctrl_decoder: directed and randomized check of alu_ctrl_decoder against a queue-based reference model
module tb_alu_ctrl_decoder;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] inst = '0;
  logic in_ready, out_valid, op1_sel, op2_sel, illegal;
  logic [3:0] alu_ctrl;
  logic [31:0] imm;
  logic [4:0] rd, rs1, rs2;
  int vectors = 0, miscompares = 0;
  typedef struct packed {
    logic [3:0] alu;
    logic op1, op2;
    logic [31:0] imm;
    logic [4:0] rd, rs1, rs2;
    logic ill;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  alu_ctrl_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl), .op1_sel(op1_sel),
    .op2_sel(op2_sel), .imm(imm), .rd(rd), .rs1(rs1), .rs2(rs2), .illegal(illegal)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [31:0] i);
    exp_t e;
    int f3, f7;
    int base [8] = '{3, 0, 8, 9, 5, 1, 6, 7};
    f3 = int'(i[14:12]);
    f7 = int'(i[31:25]);
    e = '0;
    e.alu = 4'd3;
    e.rd = i[11:7];
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    case (i[6:0])
      7'h33:
        if (f7 == 0) e.alu = 4'(base[f3]);
        else if (f7 == 32 && f3 == 0) e.alu = 4'd4;
        else if (f7 == 32 && f3 == 5) e.alu = 4'd2;
        else e.ill = 1'b1;
      7'h13:
        if ((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32)) e.ill = 1'b1;
        else begin
          e.alu = (f3 == 5 && f7 == 32) ? 4'd2 : 4'(base[f3]);
          e.op2 = 1'b1;
          e.imm = (f3 == 1 || f3 == 5) ? 32'(i[24:20]) : 32'($signed(i[31:20]));
        end
      7'h37: begin e.alu = 4'd10; e.op2 = 1'b1; e.imm = i & 32'hFFFFF000; end
      7'h17: begin e.op1 = 1'b1; e.op2 = 1'b1; e.imm = i & 32'hFFFFF000; end
      7'h03: begin e.op2 = 1'b1; e.imm = 32'($signed(i[31:20])); end
      7'h23: begin e.op2 = 1'b1; e.imm = 32'($signed({i[31:25], i[11:7]})); end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction
  task automatic cyc(input logic v, input logic [31:0] i, input logic ordy, input logic fl);
    logic a, m;
    @(negedge clk);
    in_valid = v;
    inst = i;
    out_ready = ordy;
    flush = fl;
    #1;
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("alu_ctrl", alu_ctrl, q[0].alu);
      chk("op1_sel", op1_sel, q[0].op1);
      chk("op2_sel", op2_sel, q[0].op2);
      chk("imm", imm, q[0].imm);
      chk("rd", rd, q[0].rd);
      chk("rs1", rs1, q[0].rs1);
      chk("rs2", rs2, q[0].rs2);
      chk("illegal", illegal, q[0].ill);
    end
    a = v && q.size() < 2;
    m = ordy && q.size() != 0;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (m) void'(q.pop_front());
      if (a) q.push_back(model(i));
    end
    #2;
  endtask
  function automatic logic [31:0] rnd_inst();
    logic [31:0] r;
    logic [6:0] ops [6] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23};
    int p, k;
    r = $urandom;
    p = $urandom_range(0, 7);
    k = $urandom_range(0, 3);
    if (p < 6) r[6:0] = ops[p];
    if (k == 0) r[31:25] = 7'h00;
    if (k == 1) r[31:25] = 7'h20;
    return r;
  endfunction
  initial begin
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fields", {alu_ctrl, op1_sel, op2_sel, rd, rs1, rs2, illegal}, 0);
    chk("rst_imm", imm, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    cyc(1, 32'h002081B3, 1, 0);
    chk("add_valid", out_valid, 1);
    chk("add_alu", alu_ctrl, 3);
    chk("add_regs", {rd, rs1, rs2}, {5'd3, 5'd1, 5'd2});
    chk("add_op2", op2_sel, 0);
    chk("add_ill", illegal, 0);
    cyc(1, 32'h40735293, 1, 0);
    chk("srai_alu", alu_ctrl, 2);
    chk("srai_op2", op2_sel, 1);
    chk("srai_imm", imm, 32'h7);
    chk("srai_rd", rd, 5);
    cyc(1, 32'h123450B7, 1, 0);
    chk("lui_alu", alu_ctrl, 10);
    chk("lui_imm", imm, 32'h12345000);
    cyc(0, 0, 1, 0);
    cyc(1, 32'h002081B3, 0, 0);
    cyc(1, 32'h0020C233, 0, 0);
    chk("full_in_ready", in_ready, 0);
    cyc(1, 32'h0020E2B3, 0, 0);
    chk("full_head", alu_ctrl, 3);
    cyc(1, 32'h0020E2B3, 1, 0);
    chk("second_head", alu_ctrl, 5);
    chk("or_not_taken", in_ready, 1);
    cyc(1, 32'h0020E2B3, 1, 0);
    chk("or_head", alu_ctrl, 6);
    cyc(0, 0, 1, 0);
    cyc(1, 32'hFFFFFFFF, 0, 0);
    chk("allones_ill", illegal, 1);
    chk("allones_alu", alu_ctrl, 3);
    cyc(1, 32'h40311093, 1, 0);
    chk("bad_slli_ill", illegal, 1);
    chk("bad_slli_alu", alu_ctrl, 3);
    cyc(0, 0, 1, 0);
    cyc(1, 32'h002081B3, 0, 0);
    cyc(1, 32'h0020C233, 0, 0);
    cyc(0, 0, 1, 1);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    cyc(1, 32'h002081B3, 0, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_fields", {alu_ctrl, rd, rs1, rs2}, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);
    for (int n = 0; n < 600; n++)
      cyc(1'($urandom_range(0, 2) != 0), rnd_inst(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_decoder.md
ALU_CTRL_DECODER -- requirements
Module: alu_ctrl_decoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: in_valid  in  1; in_ready  out  1; inst  in  32  RV32I instruction word; flush  in  1  discard all buffered entries.
REQ-004 SHALL have ports: out_valid  out  1; out_ready  in  1; alu_ctrl  out  4; op1_sel  out  1 (0 rs1, 1 pc); op2_sel  out  1 (0 rs2, 1 imm); imm  out  32; rd, rs1, rs2  out  5 each; illegal  out  1.
REQ-005 SHALL use alu_ctrl encoding: SLL 0, SRL 1, SRA 2, ADD 3, SUB 4, XOR 5, OR 6, AND 7, SLT 8, SLTU 9, LUI 10.

Function
REQ-006 SHALL decode one instruction per accepted beat: accept = in_valid & in_ready; emit = out_valid & out_ready.
REQ-007 SHALL buffer decoded results in a 2-entry FIFO, emitting in acceptance order.
REQ-008 SHALL drive in_ready = (count < 2) & ~rst; simultaneous accept and emit at count 2 not allowed (in_ready already 0).
REQ-009 SHALL present an accepted beat on outputs the cycle after acceptance when FIFO empty (latency 1); no combinational in-to-out path.
REQ-010 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-011 SHALL decode OP (0110011): funct3 000 ADD/SUB (inst[30]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (inst[30]), 110 OR, 111 AND; op1_sel 0, op2_sel 0, imm 0.
REQ-012 SHALL flag illegal for OP when funct7 not 0000000, or 0100000 with funct3 not 000/101.
REQ-013 SHALL decode OP-IMM (0010011) like OP minus SUB; op2_sel 1; imm = sign-ext inst[31:20]; shifts imm = zero-ext inst[24:20].
REQ-014 SHALL flag illegal for OP-IMM shifts when funct7 not 0000000 (SLLI/SRLI) or 0100000 (SRAI only, funct3 101).
REQ-015 SHALL decode LUI (0110111): alu_ctrl LUI, op2_sel 1, imm = {inst[31:12],12'h0}.
REQ-016 SHALL decode AUIPC (0010111): alu_ctrl ADD, op1_sel 1, op2_sel 1, imm = {inst[31:12],12'h0}.
REQ-017 SHALL decode LOAD (0000011): ADD, op2_sel 1, I-imm; STORE (0100011): ADD, op2_sel 1, imm = sign-ext {inst[31:25],inst[11:7]}.
REQ-018 SHALL for any other opcode set illegal 1, alu_ctrl ADD, op1_sel 0, op2_sel 0, imm 0; illegal entries still flow through the FIFO.
REQ-019 SHALL pass rd=inst[11:7], rs1=inst[19:15], rs2=inst[24:20] unmodified for every opcode.
REQ-020 SHALL on flush clear count to 0 next edge, dropping buffered entries and any beat accepted that cycle; flush overrides emit.

Reset
REQ-021 SHALL on rst assertion immediately force count 0, out_valid 0, in_ready 0, alu_ctrl 0, op1_sel 0, op2_sel 0, imm 0, rd/rs1/rs2 0, illegal 0.
REQ-022 SHALL after rst deassertion present in_ready 1 in the first cycle; a reset mid-transfer loses all buffered entries with no partial emit.

Verification
REQ-023 SHALL pass: accept 0x002081B3, out_ready 1 -> next cycle out_valid 1, alu_ctrl 3, rd 3, rs1 1, rs2 2, op2_sel 0, illegal 0.
REQ-024 SHALL pass: accept 0x40735293 (SRAI x5,x6,7) -> alu_ctrl 2, op2_sel 1, imm 0x00000007, rd 5; then 0x123450B7 (LUI) -> alu_ctrl 10, imm 0x12345000.
REQ-025 SHALL pass: out_ready 0, offer ADD, XOR, OR back-to-back -> in_ready 0 after two accepts; release out_ready -> ADD (3) then XOR (5) emitted; OR accepted only after first emit.
REQ-026 SHALL pass: accept 0xFFFFFFFF and SLLI with inst[31:25]=0100000 -> both illegal 1, alu_ctrl 3.
REQ-027 SHALL pass: FIFO holding 2 entries, flush 1 one cycle -> out_valid 0 and in_ready 1 next cycle; no entry emitted.
REQ-028 SHALL pass: rst asserted mid-cycle with 1 entry -> out_valid 0 before next clock edge; after release in_ready 1, out_valid 0.
